// File: rtl/ms7200_link_monitor.sv
// Post-init MS7200 link supervisor: polls the status register and debounces the lock bits.
// Latency: first read POLL_CYCLES clocks after init_over is sampled high; lock changes one clock after the deciding read.
// Backpressure: a poll is held while the I2C master reports busy; a stalled read is abandoned after TIMEOUT_CYCLES.
module ms7200_link_monitor #(
  parameter int unsigned POLL_CYCLES    = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000,
  parameter logic [7:0]  DEVICE_ID      = 8'h56,
  parameter logic [15:0] STAT_ADDR      = 16'h0010,
  parameter logic [7:0]  LOCK_MASK      = 8'h03,
  parameter logic [7:0]  LOCK_VAL       = 8'h03,
  parameter int unsigned LOCK_CNT       = 3,
  parameter int unsigned LOSS_CNT       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_over,
  output logic [7:0]  device_id,
  output logic        iic_trig,
  output logic        w_r,
  output logic [15:0] addr,
  output logic [7:0]  data_in,
  input  logic        busy,
  input  logic [7:0]  data_out,
  input  logic        byte_over,
  output logic        link_locked,
  output logic        reinit_req,
  output logic [7:0]  last_status,
  output logic [7:0]  err_cnt
);

  localparam int unsigned PW = $clog2(POLL_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_TRIG, S_WAIT_BYTE, S_EVAL, S_WAIT_FREE
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   poll_tmr;
  logic [TW-1:0]   to_tmr;
  logic [3:0]      good_cnt, bad_cnt;
  logic [3:0]      good_nxt, bad_nxt;
  logic            poll_done, to_done, good_read;

  // The bus request is a read of one fixed register, so these never change.
  assign device_id = DEVICE_ID;
  assign w_r       = 1'b0;
  assign addr      = STAT_ADDR;
  assign data_in   = 8'h00;

  assign poll_done = (poll_tmr == PW'(POLL_CYCLES - 1));
  assign to_done   = (to_tmr == TW'(TIMEOUT_CYCLES - 1));
  assign good_read = ((last_status & LOCK_MASK) == LOCK_VAL);
  assign good_nxt  = (good_cnt == 4'(LOCK_CNT)) ? good_cnt : good_cnt + 4'd1;
  assign bad_nxt   = (bad_cnt == 4'(LOSS_CNT)) ? bad_cnt : bad_cnt + 4'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; losing init_over abandons whatever is in progress.
  always_comb begin
    state_nxt = state;
    if (!init_over) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      state_nxt = S_WAIT;
        S_WAIT:      if (poll_done && !busy) state_nxt = S_TRIG;
        S_TRIG:      state_nxt = S_WAIT_BYTE;
        S_WAIT_BYTE: begin
          // A byte arriving on the timeout cycle still counts as a read.
          if (byte_over)    state_nxt = S_EVAL;
          else if (to_done) state_nxt = S_WAIT_FREE;
        end
        S_EVAL:      state_nxt = S_WAIT_FREE;
        S_WAIT_FREE: if (!busy) state_nxt = S_WAIT;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  // Start pulse is decoded straight from the single-cycle TRIG state.
  always_comb begin
    iic_trig = (state == S_TRIG);
  end

  // Timers, debounce counters, lock flag and status capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_tmr    <= '0;
      to_tmr      <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      link_locked <= 1'b0;
      reinit_req  <= 1'b0;
      last_status <= 8'h00;
      err_cnt     <= 8'h00;
    end else if (!init_over) begin
      // last_status and err_cnt survive a de-init for diagnostics.
      poll_tmr    <= '0;
      to_tmr      <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      link_locked <= 1'b0;
      reinit_req  <= 1'b0;
    end else begin
      reinit_req <= 1'b0;
      case (state)
        S_IDLE: poll_tmr <= '0;
        S_WAIT: if (!poll_done) poll_tmr <= poll_tmr + PW'(1);
        S_TRIG: to_tmr <= '0;
        S_WAIT_BYTE: begin
          if (byte_over) begin
            last_status <= data_out;
          end else if (to_done) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else begin
            to_tmr <= to_tmr + TW'(1);
          end
        end
        S_EVAL: begin
          if (good_read) begin
            good_cnt <= good_nxt;
            bad_cnt  <= '0;
            if (good_nxt == 4'(LOCK_CNT) && !link_locked) link_locked <= 1'b1;
          end else begin
            bad_cnt  <= bad_nxt;
            good_cnt <= '0;
            if (bad_nxt == 4'(LOSS_CNT) && link_locked) begin
              link_locked <= 1'b0;
              reinit_req  <= 1'b1;
            end
          end
        end
        S_WAIT_FREE: if (!busy) poll_tmr <= '0;
        default: ;
      endcase
    end
  end

endmodule
